count_display: RTL and testbench

Display driver that consumes the 8-bit up/down count and shows it in decimal on the board's 4-digit common-anode seven-segment display. It runs on the board clock and treats `count` as asynchronous, since the count source runs in its own slow clock domain. It synchronizes the count and converts it to BCD with a sequential double-dabble engine. It then time-multiplexes the digits with leading-zero blanking.

---
 rtl/display_pkg.sv | 45 ++++
 rtl/count_display_if.sv | 18 +
 rtl/bin2bcd_seq.sv | 75 +++++++
 rtl/count_display.sv | 133 +++++++++++++
 tb/tb_count_display.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/display_pkg.sv
// Shared definitions for the count display driver.
//   - conv_state_t : state encoding of the sequential binary-to-BCD converter
//   - SEG_0..SEG_9 : active-low segment patterns {g,f,e,d,c,b,a}
//   - SEG_BLANK    : all segments off
//   - AN_OFF       : all anodes off (active-low)
//   - seg_decode() : BCD digit to segment pattern; non-decimal codes go blank
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [3:0] AN_OFF    = 4'b1111;

  function automatic logic [6:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/count_display_if.sv
// Board-side bundle of the count display driver.
//   count : 8-bit value to show, asynchronous to the display clock
//   an    : digit anodes, active-low, an[0] = ones digit
//   seg   : segments {g,f,e,d,c,b,a}, active-low
//   dp    : decimal point, active-low
//   busy  : conversion in progress
// master = the side that supplies the count and watches the display,
// slave  = the display driver.
interface count_display_if;
  logic [7:0] count;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       busy;

  modport master (output count, input an, seg, dp, busy);
  modport slave  (input count, output an, seg, dp, busy);
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: 8-bit binary to 3 BCD digits.
//   clk, rst_n : clock, async active-low reset
//   i_bin      : binary value, sampled when i_start is accepted in IDLE
//   i_start    : start strobe (ignored while busy)
//   o_bcd      : {hundreds, tens, ones}; final only while o_done is high
//   o_busy     : high in SHIFT and COMMIT
//   o_done     : one-cycle strobe in COMMIT
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_bin,
  input  logic        i_start,
  output logic [11:0] o_bcd,
  output logic        o_busy,
  output logic        o_done
);

  conv_state_t r_state;
  conv_state_t w_next_state;
  logic [19:0] r_shift;   // {hundreds, tens, ones, binary}
  logic [2:0]  r_bit_cnt;
  logic [19:0] w_adj;

  // Add 3 to every BCD nibble >= 5 so the following shift carries correctly.
  // NOTE: every signal written in always_comb gets a default first; a path
  // that leaves it unassigned would infer a latch.
  always_comb begin
    w_adj = r_shift;
    if (r_shift[11:8]  >= 4'd5) w_adj[11:8]  = r_shift[11:8]  + 4'd3;
    if (r_shift[15:12] >= 4'd5) w_adj[15:12] = r_shift[15:12] + 4'd3;
    if (r_shift[19:16] >= 4'd5) w_adj[19:16] = r_shift[19:16] + 4'd3;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_next_state = ST_SHIFT;
      ST_SHIFT:  if (r_bit_cnt == 3'd7) w_next_state = ST_COMMIT;
      ST_COMMIT: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_shift   <= {12'b0, i_bin};
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          r_shift   <= {w_adj[18:0], 1'b0};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        default: ;
      endcase
    end
  end

  assign o_bcd  = r_shift[19:8];
  assign o_busy = (r_state != ST_IDLE);
  assign o_done = (r_state == ST_COMMIT);

endmodule

// File: rtl/count_display.sv
// Shows an asynchronous 8-bit count in decimal on a 4-digit common-anode
// seven-segment display with leading-zero blanking.
//   clk_100MHz : board clock
//   reset_n    : async active-low reset
//   bus        : count_display_if.slave (count in; an, seg, dp, busy out)
//   DIGIT_CYCLES : clocks each digit slot stays lit (>= 2)
module count_display
  import display_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000
) (
  input  logic            clk_100MHz,
  input  logic            reset_n,
  count_display_if.slave  bus
);

  localparam int             CNT_W    = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIGIT_CYCLES - 1);

  logic [7:0]       r_s1, r_s2, r_s3;
  logic [7:0]       r_cur_bin;
  logic             w_start;
  logic [11:0]      w_bcd;
  logic             w_busy;
  logic             w_done;
  logic [3:0]       r_dig_h, r_dig_t, r_dig_o;
  logic [CNT_W-1:0] r_scan_cnt;
  logic [1:0]       r_slot;
  logic             w_blank_h, w_blank_t;
  logic [3:0]       w_an_next;
  logic [6:0]       w_seg_next;
  logic [3:0]       r_an;
  logic [6:0]       r_seg;
  logic             r_dp;

  // The count bus is synchronized bit by bit; a word caught mid-change can
  // have skewed bits, so it is only accepted once two successive samples agree.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= bus.count;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_start = (r_s2 == r_s3) && (r_s2 != r_cur_bin) && !w_busy;

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) r_cur_bin <= '0;
    else if (w_start) r_cur_bin <= r_s2;
  end

  bin2bcd_seq u_bin2bcd (
    .clk     (clk_100MHz),
    .rst_n   (reset_n),
    .i_bin   (r_s2),
    .i_start (w_start),
    .o_bcd   (w_bcd),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  // Digits change only on the completed result, never on a partial shift.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_dig_h <= '0;
      r_dig_t <= '0;
      r_dig_o <= '0;
    end else if (w_done) begin
      r_dig_h <= w_bcd[11:8];
      r_dig_t <= w_bcd[7:4];
      r_dig_o <= w_bcd[3:0];
    end
  end

  // Four slots per frame; slot 3 stays dark so all lit digits get equal duty.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_cnt <= '0;
      r_slot     <= '0;
    end else if (r_scan_cnt == CNT_LAST) begin
      r_scan_cnt <= '0;
      r_slot     <= r_slot + 2'd1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

  assign w_blank_h = (r_dig_h == 4'd0);
  assign w_blank_t = w_blank_h && (r_dig_t == 4'd0);

  always_comb begin
    w_an_next  = AN_OFF;
    w_seg_next = SEG_BLANK;
    case (r_slot)
      2'd0: begin
        w_an_next  = ~(4'b0001 << r_slot);
        w_seg_next = seg_decode(r_dig_o);
      end
      2'd1: begin
        w_an_next  = ~(4'b0001 << r_slot);
        w_seg_next = w_blank_t ? SEG_BLANK : seg_decode(r_dig_t);
      end
      2'd2: begin
        w_an_next  = ~(4'b0001 << r_slot);
        w_seg_next = w_blank_h ? SEG_BLANK : seg_decode(r_dig_h);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      r_an  <= AN_OFF;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= w_an_next;
      r_seg <= w_seg_next;
      r_dp  <= 1'b1;
    end
  end

  assign bus.an   = r_an;
  assign bus.seg  = r_seg;
  assign bus.dp   = r_dp;
  assign bus.busy = w_busy;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with DIGIT_CYCLES = 4.
module tb_count_display;

  localparam int DC = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  count_display_if bus();

  count_display #(.DIGIT_CYCLES(DC)) dut (
    .clk_100MHz (clk),
    .reset_n    (rst_n),
    .bus        (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] seg_ref [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};
  logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b1111};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Change count just after an edge; the next rising edge is "edge 0".
  task automatic set_count(input logic [7:0] v);
    @(posedge clk);
    #1 bus.count = v;
  endtask

  // busy rises on edge 3 and falls on edge 12 after the change.
  task automatic check_busy_profile(input string tag);
    repeat (3) @(posedge clk);
    #1 check({tag, "_busy_e2"}, bus.busy, 1'b0);
    @(posedge clk);
    #1 check({tag, "_busy_e3"}, bus.busy, 1'b1);
    repeat (8) @(posedge clk);
    #1 check({tag, "_busy_e11"}, bus.busy, 1'b1);
    @(posedge clk);
    #1 check({tag, "_busy_e12"}, bus.busy, 1'b0);
  endtask

  // Watch one full scan frame and compare each slot with the expected digits.
  task automatic collect_display(input string tag, input int v);
    int h, t, o;
    logic [6:0] exp_h, exp_t, exp_o;
    logic [6:0] got_h, got_t, got_o;
    logic seen_dark, dark_bad, an_bad;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    exp_o = seg_ref[o];
    exp_t = (h == 0 && t == 0) ? 7'h7F : seg_ref[t];
    exp_h = (h == 0) ? 7'h7F : seg_ref[h];
    got_h = 7'h55; got_t = 7'h55; got_o = 7'h55;
    seen_dark = 1'b0; dark_bad = 1'b0; an_bad = 1'b0;
    @(posedge clk);
    repeat (4 * DC) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: got_o = bus.seg;
        4'b1101: got_t = bus.seg;
        4'b1011: got_h = bus.seg;
        4'b1111: begin
          seen_dark = 1'b1;
          if (bus.seg !== 7'h7F) dark_bad = 1'b1;
        end
        default: an_bad = 1'b1;
      endcase
    end
    check({tag, "_ones"}, got_o, exp_o);
    check({tag, "_tens"}, got_t, exp_t);
    check({tag, "_hund"}, got_h, exp_h);
    check({tag, "_dark"}, {seen_dark, dark_bad}, 2'b10);
    check({tag, "_an_legal"}, an_bad, 1'b0);
    check({tag, "_dp"}, bus.dp, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic busy_seen, found, bad_pat, seen12;
    logic [3:0] prev_an;

    // Reset and idle
    rst_n = 1'b0;
    bus.count = 8'd0;
    #22;
    check("rst_an", bus.an, 4'b1111);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_dp", bus.dp, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.busy) busy_seen = 1'b1;
    end
    check("idle_no_busy", busy_seen, 1'b0);
    collect_display("zero", 0);

    // Scan timing: 1110,1101,1011,1111 each held DC cycles
    found = 1'b0;
    @(negedge clk);
    prev_an = bus.an;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (prev_an == 4'b1111 && bus.an == 4'b1110) found = 1'b1;
      prev_an = bus.an;
    end
    check("scan_sync", found, 1'b1);
    for (int i = 1; i < 8 * DC; i++) begin
      @(negedge clk);
      check("scan_an", bus.an, an_seq[(i / DC) % 4]);
    end

    // Full range and blanking
    set_count(8'hFF);
    check_busy_profile("ff");
    collect_display("ff", 255);
    set_count(8'd7);
    check_busy_profile("v7");
    collect_display("v7", 7);
    set_count(8'd40);
    check_busy_profile("v40");
    collect_display("v40", 40);
    set_count(8'd100);
    check_busy_profile("v100");
    collect_display("v100", 100);

    // Mid-conversion change 12 -> 200, applied 2 cycles into SHIFT
    set_count(8'd12);
    repeat (3) @(posedge clk);
    #1 check("mid_busy_e2", bus.busy, 1'b0);
    @(posedge clk);
    #1 check("mid_busy_e3", bus.busy, 1'b1);
    repeat (2) @(posedge clk);
    #1 bus.count = 8'd200;
    repeat (6) @(posedge clk);
    #1 check("mid_busy_e11", bus.busy, 1'b1);
    @(posedge clk);
    #1 check("mid_busy_e12", bus.busy, 1'b0);
    @(posedge clk);
    #1 check("mid_busy_e13", bus.busy, 1'b1);
    bad_pat = 1'b0;
    seen12 = 1'b0;
    repeat (40) begin
      @(negedge clk);
      case (bus.an)
        4'b1110: begin
          if (bus.seg !== seg_ref[2] && bus.seg !== seg_ref[0]) bad_pat = 1'b1;
          if (bus.seg === seg_ref[2]) seen12 = 1'b1;
        end
        4'b1101: begin
          if (bus.seg !== seg_ref[1] && bus.seg !== seg_ref[0]) bad_pat = 1'b1;
          if (bus.seg === seg_ref[1]) seen12 = 1'b1;
        end
        4'b1011: if (bus.seg !== 7'h7F && bus.seg !== seg_ref[2]) bad_pat = 1'b1;
        4'b1111: if (bus.seg !== 7'h7F) bad_pat = 1'b1;
        default: bad_pat = 1'b1;
      endcase
    end
    check("mid_only_legal", bad_pat, 1'b0);
    check("mid_saw_12", seen12, 1'b1);
    collect_display("v200", 200);

    // Reset mid-conversion with count = 99
    set_count(8'd99);
    repeat (6) @(posedge clk);
    #1 check("rmid_busy", bus.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rmid_an", bus.an, 4'b1111);
    check("rmid_seg", bus.seg, 7'h7F);
    check("rmid_busy_clr", bus.busy, 1'b0);
    check("rmid_dp", bus.dp, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_busy_profile("v99");
    collect_display("v99", 99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
